// File: rtl/wb_sram.sv
`timescale 1ns / 1ps
// Wishbone pipelined SRAM responder: byte-selectable word array, fixed-latency ack/err,
// and a zero-fill sweep of the whole array after every reset while the bus is stalled.
module wb_sram #(
    parameter int unsigned AddrBits = 8,
    parameter int unsigned Latency  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] bus_data_m,
    input  logic [31:0] bus_addr,
    input  logic [3:0]  bus_sel,
    input  logic        bus_cyc,
    input  logic        bus_stb,
    input  logic        bus_we,
    output logic [31:0] bus_data_s,
    output logic        bus_ack,
    output logic        bus_stall,
    output logic        bus_err
);

    localparam int unsigned Words = 2 ** AddrBits;

    localparam logic [0:0] StInit = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic [AddrBits-1:0] cnt_q, cnt_d;
    logic [31:0]         mem_q [Words];

    logic [Latency-1:0]  ack_q, err_q;
    logic [31:0]         data_q [Latency];

    logic                accept;
    logic                in_range;
    logic [AddrBits-1:0] idx;
    logic                new_ack, new_err;
    logic [31:0]         new_data;
    logic                unused_addr;

    // Bits [31:28] belong to the multiplexer's region decode.
    assign unused_addr = ^bus_addr[31:28];

    assign bus_stall = (state_q != StRun);
    assign accept    = bus_cyc & bus_stb & ~bus_stall;
    assign idx       = bus_addr[AddrBits+1:2];
    assign in_range  = (({4'b0000, bus_addr[27:0]} >> (AddrBits + 2)) == 32'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == StInit) begin
            cnt_d = cnt_q + AddrBits'(1);
            if (&cnt_q) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (state_q == StInit) begin
                mem_q[cnt_q] <= '0;
            end else if (accept && bus_we && in_range) begin
                for (int i = 0; i < 4; i++) begin
                    if (bus_sel[i]) begin
                        mem_q[idx][8*i +: 8] <= bus_data_m[8*i +: 8];
                    end
                end
            end
        end
    end

    // Write acks and errors carry zero data so bus_data_s is zero whenever ack is low.
    always_comb begin
        new_ack  = accept & in_range;
        new_err  = accept & ~in_range;
        new_data = (accept && in_range && !bus_we) ? mem_q[idx] : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !bus_cyc) begin
            ack_q <= '0;
            err_q <= '0;
            for (int i = 0; i < Latency; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            ack_q[0]  <= new_ack;
            err_q[0]  <= new_err;
            data_q[0] <= new_data;
            for (int i = 1; i < Latency; i++) begin
                ack_q[i]  <= ack_q[i-1];
                err_q[i]  <= err_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign bus_ack    = ack_q[Latency-1];
    assign bus_err    = err_q[Latency-1];
    assign bus_data_s = data_q[Latency-1];

endmodule

// File: tb/tb_wb_sram.sv
`timescale 1ns / 1ps
// Bench for wb_sram: two instances (latency 1 and 3) share one bus; a reference memory model
// predicts each response, and a negedge monitor matches responses against per-instance queues.
module tb_wb_sram;

    localparam int unsigned AddrBits = 8;
    localparam int unsigned Words    = 256;

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] data_m = '0;
    logic [31:0] addr = '0;
    logic [3:0]  sel = '0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [31:0] data_s [2];
    logic        ack [2];
    logic        err [2];
    logic        stall [2];

    exp_t        exp_q [2][$];
    logic [31:0] ref_mem [Words];
    int          errors = 0;
    int          checks = 0;
    int          cyc_cnt = 0;
    int          resp_cnt [2] = '{0, 0};

    wb_sram #(.AddrBits(AddrBits), .Latency(1)) u_dut_l1 (
        .clk(clk), .reset_n(reset_n), .bus_data_m(data_m), .bus_addr(addr), .bus_sel(sel),
        .bus_cyc(cyc), .bus_stb(stb), .bus_we(we), .bus_data_s(data_s[0]), .bus_ack(ack[0]),
        .bus_stall(stall[0]), .bus_err(err[0])
    );

    wb_sram #(.AddrBits(AddrBits), .Latency(3)) u_dut_l3 (
        .clk(clk), .reset_n(reset_n), .bus_data_m(data_m), .bus_addr(addr), .bus_sel(sel),
        .bus_cyc(cyc), .bus_stb(stb), .bus_we(we), .bus_data_s(data_s[1]), .bus_ack(ack[1]),
        .bus_stall(stall[1]), .bus_err(err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endtask

    // Monitor: responses become visible after a posedge and are sampled on the negedge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            while (exp_q[d].size() > 0 && exp_q[d][0].due < cyc_cnt) begin
                check($sformatf("missing_resp_l%0d", lat(d)), 32'd0, 32'd1);
                void'(exp_q[d].pop_front());
            end
            check($sformatf("ack_err_exclusive_l%0d", lat(d)), 32'(ack[d] & err[d]), 32'd0);
            if (ack[d] || err[d]) begin
                resp_cnt[d]++;
                if (exp_q[d].size() == 0) begin
                    check($sformatf("spurious_resp_l%0d", lat(d)), {30'd0, err[d], ack[d]}, 32'd0);
                end else begin
                    e = exp_q[d].pop_front();
                    check($sformatf("resp_cycle_l%0d", lat(d)), 32'(cyc_cnt), 32'(e.due));
                    check($sformatf("resp_kind_l%0d", lat(d)), {30'd0, err[d], ack[d]},
                          {30'd0, e.err, ~e.err});
                    check($sformatf("resp_data_l%0d", lat(d)), data_s[d], e.data);
                end
            end else begin
                check($sformatf("idle_data_zero_l%0d", lat(d)), data_s[d], 32'd0);
            end
        end
    end

    task automatic push(input bit e, input logic [31:0] dat);
        exp_t x;
        for (int d = 0; d < 2; d++) begin
            x.due  = cyc_cnt + lat(d);
            x.err  = e;
            x.data = dat;
            exp_q[d].push_back(x);
        end
    endtask

    // Responses due after the next edge are discarded by an abort or reset on that edge.
    task automatic drop_after(input int c);
        for (int d = 0; d < 2; d++) begin
            while (exp_q[d].size() > 0 && exp_q[d][exp_q[d].size()-1].due > c) begin
                void'(exp_q[d].pop_back());
            end
        end
    endtask

    task automatic req(input bit w, input logic [31:0] a, input logic [31:0] dat,
                       input logic [3:0] s);
        logic [AddrBits-1:0] idx;
        bit                  inr;
        idx = a[AddrBits+1:2];
        inr = (a[27:AddrBits+2] == '0);
        check("stall_at_req_l1", 32'(stall[0]), 32'd0);
        check("stall_at_req_l3", 32'(stall[1]), 32'd0);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; data_m = dat; sel = s;
        if (!inr) begin
            push(1'b1, 32'd0);
        end else if (w) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) ref_mem[idx][8*i +: 8] = dat[8*i +: 8];
            end
            push(1'b0, 32'd0);
        end else begin
            push(1'b0, ref_mem[idx]);
        end
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
    endtask

    task automatic drain();
        stb = 1'b0;
        for (int i = 0; i < 20 && (exp_q[0].size() + exp_q[1].size()) > 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_pending", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
        cyc = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic abort_cycle();
        cyc = 1'b0;
        stb = 1'($urandom);
        drop_after(cyc_cnt);
        @(posedge clk); #1;
        stb = 1'b0;
    endtask

    task automatic do_reset();
        int n0, n1;
        reset_n = 1'b0; cyc = 1'b0; stb = 1'b0;
        drop_after(cyc_cnt);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("stall_in_reset_l1", 32'(stall[0]), 32'd1);
        check("stall_in_reset_l3", 32'(stall[1]), 32'd1);
        for (int i = 0; i < Words; i++) ref_mem[i] = '0;
        reset_n = 1'b1;
        n0 = -1; n1 = -1;
        for (int n = 1; n <= 1000 && (n0 < 0 || n1 < 0); n++) begin
            @(posedge clk); #1;
            if (n0 < 0 && stall[0] == 1'b0) n0 = n;
            if (n1 < 0 && stall[1] == 1'b0) n1 = n;
        end
        check("init_stall_cycles_l1", 32'(n0), 32'd256);
        check("init_stall_cycles_l3", 32'(n1), 32'd256);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 100000",
                 cyc_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1;
        logic [31:0] a;
        for (int i = 0; i < Words; i++) ref_mem[i] = '0;
        @(posedge clk); #1;
        do_reset();

        // Freshly cleared word, then full write with back-to-back read.
        req(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        drain();
        req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        drain();

        // Byte selects, including the sel = 0 no-op write.
        req(1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF);
        req(1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5);
        req(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        req(1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0);
        req(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        drain();

        // Pipelined burst of reads.
        req(1'b1, 32'h0000_0000, 32'hA, 4'hF);
        req(1'b1, 32'h0000_0004, 32'hB, 4'hF);
        req(1'b1, 32'h0000_0008, 32'hC, 4'hF);
        req(1'b0, 32'h0000_0000, 32'h0, 4'h0);
        req(1'b0, 32'h0000_0004, 32'h0, 4'h0);
        req(1'b0, 32'h0000_0008, 32'h0, 4'h0);
        drain();

        // Out of range reads and writes, and ignored high region bits.
        req(1'b0, 32'h0000_0400, 32'h0, 4'h0);
        req(1'b1, 32'h0800_0010, 32'h5555_5555, 4'hF);
        req(1'b0, 32'hF000_0010, 32'h0, 4'h0);
        drain();

        // Abort: latency-3 response is dropped, latency-1 response is already out.
        r0 = resp_cnt[0]; r1 = resp_cnt[1];
        req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        abort_cycle();
        repeat (6) begin @(posedge clk); #1; end
        check("abort_resp_l1", 32'(resp_cnt[0] - r0), 32'd1);
        check("abort_resp_l3", 32'(resp_cnt[1] - r1), 32'd0);

        // Reset with two reads in flight on the latency-3 instance.
        req(1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF);
        drain();
        r1 = resp_cnt[1];
        req(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        do_reset();
        check("reset_inflight_l3", 32'(resp_cnt[1] - r1), 32'd0);
        req(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        req(1'b0, 32'h0000_0010, 32'h0, 4'h0);
        drain();

        // Random traffic concentrated on a few words to exercise read-after-write.
        for (int it = 0; it < 400; it++) begin
            int x;
            x = $urandom_range(0, 15);
            if (x == 0) begin
                cyc = 1'b1; stb = 1'b0;
                @(posedge clk); #1;
            end else if (x == 1) begin
                abort_cycle();
            end else begin
                a = {4'($urandom), 18'd0, 8'($urandom_range(0, 15)), 2'($urandom)};
                if ($urandom_range(0, 7) == 0) a[10 + $urandom_range(0, 17)] = 1'b1;
                req(1'($urandom), a, $urandom, 4'($urandom));
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_sram.md
Name: wb_sram

Overview:
- Wishbone pipelined-mode responder: a single-port word-addressed SRAM slave for the wb_multiplexer slave ports.
- Accepts back-to-back reads and writes with byte selects.
- Returns ack or err after a fixed, parameterised latency.
- After every reset it zero-clears its whole array while stalling the bus, so software sees deterministic contents.

Parameters:
- AddrBits, 8, log2 of word count; array is 2**AddrBits x 32-bit words.
- Latency, 1, cycles from request acceptance to ack/err; legal range 1..4.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  synchronous active-low reset, sampled on posedge clk.
- bus_data_m  input  32  write data from master.
- bus_addr  input  32  byte address; [1:0] ignored.
- bus_sel  input  4  byte enables for writes; bit i covers data[8i+7:8i].
- bus_cyc  input  1  cycle valid.
- bus_stb  input  1  request strobe.
- bus_we  input  1  1 = write, 0 = read.
- bus_data_s  output  32  read data; valid only while bus_ack is high.
- bus_ack  output  1  successful completion, one per accepted in-range request.
- bus_stall  output  1  request not accepted this cycle.
- bus_err  output  1  error completion, one per accepted out-of-range request.

Behaviour:
- Reset: applies whenever reset_n = 0 at posedge clk, including mid-transfer. Bus outputs are driven as follows:
  - bus_ack = 0, bus_err = 0, bus_data_s = 0, bus_stall = 1.
  - Response pipeline cleared; any in-flight responses are dropped and never acked.
- State machine: INIT -> RUN.
  - Entered in INIT from reset.
  - INIT: bus_stall = 1; an AddrBits-wide counter writes 0 to word[counter] each cycle, starting at 0.
  - After the write of the last word (2**AddrBits - 1), go to RUN. INIT therefore lasts exactly 2**AddrBits cycles after reset release.
  - RUN: bus_stall = 0 constantly. No return to INIT except via reset.
- Acceptance:
  - A request is accepted in a cycle where bus_cyc & bus_stb & !bus_stall.
  - Word index = bus_addr[AddrBits+1:2].
  - In range iff bus_addr[27:AddrBits+2] == 0; bits [31:28] are ignored (region decode is done by the multiplexer).
- Write, in range: on the acceptance edge, each byte with bus_sel[i] = 1 takes bus_data_m's byte i; other bytes are unchanged. bus_sel = 0 is legal: the write is a no-op but is still acked.
- Read, in range: array read on the acceptance edge.
  - A read accepted the cycle after a write to the same word returns the new data.
  - A read and a write never share a cycle (one request per cycle).
- Out of range: no array access; completes with bus_err instead of bus_ack.
- Response pipeline: Latency stages, each holding {valid, err, data}.
  - A request accepted at edge N produces its response at edge N+Latency-1, i.e. it is visible in the cycle after edge N+Latency-1.
  - With Latency = 1, ack is high in the cycle immediately after acceptance.
  - Full throughput: one response per cycle, in order.
  - bus_ack, bus_err and bus_data_s are registered outputs.
  - bus_ack and bus_err are never both high.
  - bus_data_s = 0 whenever bus_ack = 0, including on err and on write acks (write acks return 0).
- Cycle abort: if bus_cyc = 0 in any cycle, all pipeline valid bits are cleared on that edge. Pending responses are discarded and no late ack appears. Array writes already performed stay performed.
- bus_stb without bus_cyc is ignored.

Test Plan:
- Reset release, AddrBits = 8:
  - bus_stall stays 1 for exactly 256 cycles, then 0.
  - Read of 0x0000_0040 -> ack with data 0x0000_0000.
- Full write, read back, Latency = 1:
  - Write 0xDEADBEEF, sel = 0xF, to 0x0000_0010.
  - Read 0x0000_0010 on the next cycle -> ack one cycle after acceptance, data 0xDEADBEEF.
- Byte select:
  - Word holds 0x11223344.
  - Write 0xAABBCCDD with sel = 0x5 -> read returns 0x11BB33DD.
- Pipelined burst, Latency = 3:
  - Reads to words 0, 1, 2 on three consecutive cycles (data 0xA, 0xB, 0xC).
  - Acks on three consecutive cycles starting 3 cycles after the first acceptance, in order, with matching data; bus_stall = 0 throughout.
- Out-of-range and abort:
  - Read of 0x0000_0400 (AddrBits = 8) -> bus_err = 1, bus_ack = 0, bus_data_s = 0.
  - With Latency = 3, issue a read then drop bus_cyc the next cycle -> no ack or err ever appears.
- Reset mid-operation:
  - Assert reset_n = 0 with 2 responses in flight -> no ack is emitted.
  - After release, stall is high for 256 cycles and previously written words read back as 0.
